// File: rtl/prv_trap_sequencer.sv
// Trap sequencer: arbitrates exceptions/mret/interrupts, commits mepc/mcause/mtval, redirects fetch.
// Optional macro RMGMT_TRAP_EN lets RISC-MGMT extension exceptions raise a trap.
module prv_trap_sequencer #(
  parameter int unsigned NUM_EXTENSIONS = 1,
  localparam int unsigned CauseW = (NUM_EXTENSIONS > 1) ? $clog2(NUM_EXTENSIONS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fault_insn,
  input  logic              i_mal_insn,
  input  logic              i_illegal_insn,
  input  logic              i_fault_l,
  input  logic              i_mal_l,
  input  logic              i_fault_s,
  input  logic              i_mal_s,
  input  logic              i_breakpoint,
  input  logic              i_env_m,
  input  logic              i_ret,
  input  logic              i_pipe_clear,
  input  logic [31:0]       i_epc,
  input  logic [31:0]       i_badaddr,
  input  logic              i_ex_rmgmt,
  input  logic [CauseW-1:0] i_ex_rmgmt_cause,
  input  logic              i_timer_int,
  input  logic              i_soft_int,
  input  logic              i_ext_int,
  input  logic              i_mtie,
  input  logic              i_msie,
  input  logic              i_meie,
  input  logic              i_mstatus_mie,
  input  logic [31:0]       i_mtvec,
  input  logic [31:0]       i_mepc_r,
  output logic              o_intr,
  output logic              o_insert_pc,
  output logic [31:0]       o_priv_pc,
  output logic              o_mepc_we,
  output logic              o_mcause_we,
  output logic              o_mtval_we,
  output logic [31:0]       o_mepc_wdata,
  output logic [31:0]       o_mcause_wdata,
  output logic [31:0]       o_mtval_wdata,
  output logic              o_mie_push,
  output logic              o_mie_pop,
  output logic              o_busy
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StIntrWait = 3'd1;
  localparam logic [2:0] StCommit   = 3'd2;
  localparam logic [2:0] StRedirect = 3'd3;
  localparam logic [2:0] StRet      = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic        r_is_int;
  logic        r_tval_en;
  logic [30:0] r_code;
  logic [31:0] r_epc;
  logic [31:0] r_badaddr;

  logic        w_exc;
  logic        w_exc_tval;
  logic [30:0] w_exc_code;
  logic        w_int;
  logic [30:0] w_int_code;
  logic [31:0] w_trap_pc;

`ifndef RMGMT_TRAP_EN
  logic w_unused;
  assign w_unused = ^{i_ex_rmgmt, i_ex_rmgmt_cause};
`endif

  // Fixed exception priority; tval only meaningful for address/instruction faults.
  always_comb begin
    w_exc      = 1'b1;
    w_exc_tval = 1'b1;
    w_exc_code = 31'd0;
    if (i_fault_insn) begin
      w_exc_code = 31'd1;
    end else if (i_illegal_insn) begin
      w_exc_code = 31'd2;
    end else if (i_mal_insn) begin
      w_exc_code = 31'd0;
    end else if (i_breakpoint) begin
      w_exc_code = 31'd3;
      w_exc_tval = 1'b0;
    end else if (i_env_m) begin
      w_exc_code = 31'd11;
      w_exc_tval = 1'b0;
    end else if (i_mal_s) begin
      w_exc_code = 31'd6;
    end else if (i_mal_l) begin
      w_exc_code = 31'd4;
    end else if (i_fault_s) begin
      w_exc_code = 31'd7;
    end else if (i_fault_l) begin
      w_exc_code = 31'd5;
`ifdef RMGMT_TRAP_EN
    end else if (i_ex_rmgmt) begin
      w_exc_code = 31'd24 + 31'(i_ex_rmgmt_cause);
`endif
    end else begin
      w_exc      = 1'b0;
      w_exc_tval = 1'b0;
    end
  end

  always_comb begin
    w_int = i_mstatus_mie &
            ((i_ext_int & i_meie) | (i_soft_int & i_msie) | (i_timer_int & i_mtie));
    if (i_ext_int & i_meie) begin
      w_int_code = 31'd11;
    end else if (i_soft_int & i_msie) begin
      w_int_code = 31'd3;
    end else begin
      w_int_code = 31'd7;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (w_exc) begin
          w_state_nxt = StCommit;
        end else if (i_ret) begin
          w_state_nxt = StRet;
        end else if (w_int) begin
          w_state_nxt = StIntrWait;
        end
      end
      StIntrWait: if (i_pipe_clear) w_state_nxt = StCommit;
      StCommit:   w_state_nxt = StRedirect;
      StRedirect: w_state_nxt = StIdle;
      StRet:      w_state_nxt = StIdle;
      default:    w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_is_int  <= 1'b0;
      r_tval_en <= 1'b0;
      r_code    <= 31'd0;
      r_epc     <= 32'd0;
      r_badaddr <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StIdle) begin
        if (w_exc) begin
          r_is_int  <= 1'b0;
          r_tval_en <= w_exc_tval;
          r_code    <= w_exc_code;
          r_epc     <= i_epc;
          r_badaddr <= i_badaddr;
        end else if (!i_ret && w_int) begin
          r_is_int  <= 1'b1;
          r_tval_en <= 1'b0;
          r_code    <= w_int_code;
        end
      end else if (r_state == StIntrWait && i_pipe_clear) begin
        r_epc <= i_epc;
      end
    end
  end

  // Vectored mode offsets only interrupts; the add wraps modulo 2^32.
  assign w_trap_pc = {i_mtvec[31:2], 2'b00} +
                     ((r_is_int && i_mtvec[1:0] == 2'b01) ? {r_code[29:0], 2'b00} : 32'd0);

  // Outputs are pure state decodes so an asynchronous reset zeroes them at once.
  always_comb begin
    o_busy         = (r_state != StIdle);
    o_intr         = (r_state == StIntrWait);
    o_mepc_we      = (r_state == StCommit);
    o_mcause_we    = (r_state == StCommit);
    o_mtval_we     = (r_state == StCommit);
    o_mie_push     = (r_state == StCommit);
    o_mie_pop      = (r_state == StRet);
    o_insert_pc    = (r_state == StRedirect) || (r_state == StRet);
    o_mepc_wdata   = (r_state == StCommit) ? r_epc : 32'd0;
    o_mcause_wdata = (r_state == StCommit) ? {r_is_int, r_code} : 32'd0;
    o_mtval_wdata  = (r_state == StCommit && r_tval_en) ? r_badaddr : 32'd0;
    o_priv_pc      = 32'd0;
    if (r_state == StRedirect) begin
      o_priv_pc = w_trap_pc;
    end else if (r_state == StRet) begin
      o_priv_pc = i_mepc_r;
    end
  end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Directed bench for prv_trap_sequencer: expected trap records are queued at stimulus time
// and popped when the DUT commits or redirects.
module tb_prv_trap_sequencer;

  typedef struct {
    logic [31:0] mcause;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic [31:0] pc;
    logic        is_ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s;
  logic        breakpoint, env_m, ret, pipe_clear;
  logic [31:0] epc, badaddr, mtvec, mepc_r;
  logic        ex_rmgmt;
  logic [0:0]  ex_rmgmt_cause;
  logic        timer_int, soft_int, ext_int, mtie, msie, meie, mstatus_mie;
  logic        intr, insert_pc, mepc_we, mcause_we, mtval_we, mie_push, mie_pop, busy;
  logic [31:0] priv_pc, mepc_wdata, mcause_wdata, mtval_wdata;
  logic [7:0]  flags;

  assign flags = {busy, intr, insert_pc, mepc_we, mcause_we, mtval_we, mie_push, mie_pop};

  always #5 clk = ~clk;

  prv_trap_sequencer #(.NUM_EXTENSIONS(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_fault_insn(fault_insn), .i_mal_insn(mal_insn), .i_illegal_insn(illegal_insn),
    .i_fault_l(fault_l), .i_mal_l(mal_l), .i_fault_s(fault_s), .i_mal_s(mal_s),
    .i_breakpoint(breakpoint), .i_env_m(env_m), .i_ret(ret), .i_pipe_clear(pipe_clear),
    .i_epc(epc), .i_badaddr(badaddr), .i_ex_rmgmt(ex_rmgmt),
    .i_ex_rmgmt_cause(ex_rmgmt_cause),
    .i_timer_int(timer_int), .i_soft_int(soft_int), .i_ext_int(ext_int),
    .i_mtie(mtie), .i_msie(msie), .i_meie(meie), .i_mstatus_mie(mstatus_mie),
    .i_mtvec(mtvec), .i_mepc_r(mepc_r),
    .o_intr(intr), .o_insert_pc(insert_pc), .o_priv_pc(priv_pc),
    .o_mepc_we(mepc_we), .o_mcause_we(mcause_we), .o_mtval_we(mtval_we),
    .o_mepc_wdata(mepc_wdata), .o_mcause_wdata(mcause_wdata), .o_mtval_wdata(mtval_wdata),
    .o_mie_push(mie_push), .o_mie_pop(mie_pop), .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] mc, input logic [31:0] me, input logic [31:0] mt,
                          input logic [31:0] pc, input logic r);
    exp_t e;
    e.mcause = mc; e.mepc = me; e.mtval = mt; e.pc = pc; e.is_ret = r;
    exp_q.push_back(e);
  endtask

  task automatic clear_req();
    {fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s} = '0;
    {breakpoint, env_m, ret, pipe_clear, ex_rmgmt} = '0;
    {timer_int, soft_int, ext_int} = '0;
  endtask

  task automatic pop_exp(output exp_t e, output logic ok);
    ok = (exp_q.size() != 0);
    if (ok) begin
      e = exp_q.pop_front();
    end else begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      e.mcause = '0; e.mepc = '0; e.mtval = '0; e.pc = '0; e.is_ret = 1'b0;
    end
  endtask

  // Request (or pipe_clear) already presented this cycle: commit next, redirect after.
  task automatic do_trap(input string tag);
    exp_t e;
    logic ok;
    cyc();
    @(negedge clk);
    pop_exp(e, ok);
    chk({tag, "_commit_flags"}, {24'd0, flags}, 32'h9E);
    chk({tag, "_mcause"}, mcause_wdata, e.mcause);
    chk({tag, "_mepc"}, mepc_wdata, e.mepc);
    chk({tag, "_mtval"}, mtval_wdata, e.mtval);
    cyc();
    @(negedge clk);
    chk({tag, "_redir_flags"}, {24'd0, flags}, 32'hA0);
    chk({tag, "_priv_pc"}, priv_pc, e.pc);
    cyc();
    clear_req();
    @(negedge clk);
    chk({tag, "_idle_flags"}, {24'd0, flags}, 32'h00);
  endtask

  task automatic do_ret(input string tag);
    exp_t e;
    logic ok;
    cyc();
    @(negedge clk);
    pop_exp(e, ok);
    chk({tag, "_is_ret"}, {31'd0, e.is_ret}, 32'd1);
    chk({tag, "_flags"}, {24'd0, flags}, 32'hA1);
    chk({tag, "_priv_pc"}, priv_pc, e.pc);
    cyc();
    clear_req();
    @(negedge clk);
    chk({tag, "_after_flags"}, {24'd0, flags}, 32'h00);
  endtask

  initial begin
    rst = 1'b1;
    clear_req();
    epc = '0; badaddr = '0; mtvec = '0; mepc_r = '0; ex_rmgmt_cause = '0;
    {mtie, msie, meie, mstatus_mie} = '0;
    #1;
    chk("reset_flags", {24'd0, flags}, 32'h00);
    chk("reset_data", priv_pc | mepc_wdata | mcause_wdata | mtval_wdata, 32'h0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Illegal instruction, direct vector
    mtvec = 32'h800; illegal_insn = 1'b1; epc = 32'h100; badaddr = 32'hDEAD;
    push_exp(32'd2, 32'h100, 32'hDEAD, 32'h800, 1'b0);
    do_trap("illegal");

    // fault_insn outranks mal_l
    fault_insn = 1'b1; mal_l = 1'b1; epc = 32'h200; badaddr = 32'h1234;
    push_exp(32'd1, 32'h200, 32'h1234, 32'h800, 1'b0);
    do_trap("fault_vs_mal");

    // mal_s outranks fault_l
    mal_s = 1'b1; fault_l = 1'b1; epc = 32'h210; badaddr = 32'h4444;
    push_exp(32'd6, 32'h210, 32'h4444, 32'h800, 1'b0);
    do_trap("mals_vs_faultl");

    // Exception beats mret; env_m carries no tval
    ret = 1'b1; env_m = 1'b1; epc = 32'h300; badaddr = 32'h55;
    push_exp(32'd11, 32'h300, 32'h0, 32'h800, 1'b0);
    do_trap("envm_vs_ret");

    // Pending interrupt with global enable off must not start
    ext_int = 1'b1; meie = 1'b1; mstatus_mie = 1'b0;
    cyc();
    @(negedge clk);
    chk("int_masked_flags", {24'd0, flags}, 32'h00);

    // ext+timer, vectored, pipe_clear three cycles after the request
    mstatus_mie = 1'b1; timer_int = 1'b1; mtie = 1'b1; mtvec = 32'h1001;
    epc = 32'h999; badaddr = 32'hBEEF;
    push_exp(32'h8000000B, 32'h40, 32'h0, 32'h102C, 1'b0);
    cyc();
    @(negedge clk);
    chk("int_wait1", {24'd0, flags}, 32'hC0);
    cyc();
    @(negedge clk);
    chk("int_wait2", {24'd0, flags}, 32'hC0);
    cyc();
    pipe_clear = 1'b1; epc = 32'h40;
    @(negedge clk);
    chk("int_wait3", {24'd0, flags}, 32'hC0);
    do_trap("ext_int_vec");

    // soft outranks timer; direct mode ignores the cause offset
    soft_int = 1'b1; msie = 1'b1; timer_int = 1'b1; mtvec = 32'h1000;
    push_exp(32'h80000003, 32'h80, 32'h0, 32'h1000, 1'b0);
    cyc();
    pipe_clear = 1'b1; epc = 32'h80;
    @(negedge clk);
    chk("soft_wait", {24'd0, flags}, 32'hC0);
    do_trap("soft_int");

    // Vectored target wraps past 2^32
    ext_int = 1'b1; mtvec = 32'hFFFF_FFF1;
    push_exp(32'h8000000B, 32'hC0, 32'h0, 32'h0000_001C, 1'b0);
    cyc();
    pipe_clear = 1'b1; epc = 32'hC0;
    @(negedge clk);
    chk("wrap_wait", {24'd0, flags}, 32'hC0);
    do_trap("vec_wrap");

    // mret
    mtvec = 32'h800; ret = 1'b1; mepc_r = 32'h2000;
    push_exp(32'd0, 32'd0, 32'd0, 32'h2000, 1'b1);
    do_ret("mret");

    // Reset while in COMMIT aborts the trap
    illegal_insn = 1'b1; epc = 32'h10; badaddr = 32'hAA;
    cyc();
    chk("rst_pre_commit", {24'd0, flags}, 32'h9E);
    rst = 1'b1;
    #1;
    chk("rst_abort_flags", {24'd0, flags}, 32'h00);
    chk("rst_abort_data", priv_pc | mepc_wdata | mcause_wdata | mtval_wdata, 32'h0);
    clear_req();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_redirect", {24'd0, flags}, 32'h00);
    end

    // RISC-MGMT extension exception
    ex_rmgmt = 1'b1; ex_rmgmt_cause = 1'b1; epc = 32'h500; badaddr = 32'h77;
`ifdef RMGMT_TRAP_EN
    push_exp(32'd25, 32'h500, 32'h77, 32'h800, 1'b0);
    do_trap("rmgmt");
`else
    cyc();
    @(negedge clk);
    chk("rmgmt_ignored1", {24'd0, flags}, 32'h00);
    cyc();
    @(negedge clk);
    chk("rmgmt_ignored2", {24'd0, flags}, 32'h00);
    clear_req();
`endif

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
